// File: rtl/ysyx_23060187_rf_wb_arbiter_if.sv
// Write-back bus bundle for the GPR write-port arbiter: IDU issue handshake,
// two write-back producers, the registered register-file write port and the
// scoreboard query pair.
//
// Handshake semantics (issue, req0, req1): a transfer happens in a cycle
// where valid && ready are both high at the rising clock edge. ready may be
// high while valid is low. A producer holding valid high with ready low must
// keep its addr/data stable until the transfer happens.
interface ysyx_23060187_rf_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic                  issue_ready;

  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  logic [ADDR_WIDTH-1:0] q_addr1;
  logic [ADDR_WIDTH-1:0] q_addr2;
  logic                  q_busy1;
  logic                  q_busy2;

  // Producer / IDU / register-file side.
  modport master (
    output issue_valid, issue_rd,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output q_addr1, q_addr2,
    input  issue_ready, req0_ready, req1_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  q_busy1, q_busy2
  );

  // Arbiter side.
  modport slave (
    input  issue_valid, issue_rd,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  q_addr1, q_addr2,
    output issue_ready, req0_ready, req1_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output q_busy1, q_busy2
  );
endinterface

// File: rtl/ysyx_23060187_rf_wb_arbiter.sv
// GPR write-port owner: round-robin arbitration between EXU (req0) and LSU
// (req1) write-backs, one registered register-file write per cycle, and a
// per-register busy scoreboard used by IDU for RAW/WAW hazard checks.
module ysyx_23060187_rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  ysyx_23060187_rf_wb_arbiter_if.slave bus,
  output logic dbg_rr
);
  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic                  rr_q, rr_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREGS-1:0]      busy_q, busy_d;

  logic                  grant0, grant1, fire;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  issue_ready;
  logic                  issue_fire;

  // Arbitration: a lone requester always wins; on a tie rr picks, and rr
  // then points at whoever did not win so the loser goes next.
  always_comb begin
    grant0   = bus.req0_valid && (!bus.req1_valid || !rr_q);
    grant1   = bus.req1_valid && (!bus.req0_valid || rr_q);
    fire     = grant0 || grant1;
    sel_addr = grant1 ? bus.req1_addr : bus.req0_addr;
    sel_data = grant1 ? bus.req1_data : bus.req0_data;
    rr_d     = rr_q;
    if (grant0) begin
      rr_d = 1'b1;
    end else if (grant1) begin
      rr_d = 1'b0;
    end
  end

  // Write stage: the winning request is registered; x0 writes are accepted
  // but never reach the register file. Address/data hold when idle.
  always_comb begin
    rf_wen_d   = fire && (sel_addr != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_wen_d) begin
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  // Issue gating: an instruction may not issue while an older write to the
  // same destination is still pending. busy_q[0] is always 0 so x0 is free.
  always_comb begin
    issue_ready = !busy_q[bus.issue_rd];
    issue_fire  = bus.issue_valid && issue_ready && (bus.issue_rd != '0);
  end

  // Scoreboard: clear on the edge the register file commits, then apply the
  // issue set so a newer pending writer to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops any staged write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rr_q       <= rr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.rf_wen      = rf_wen_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.q_busy1     = busy_q[bus.q_addr1];
  assign bus.q_busy2     = busy_q[bus.q_addr2];
  assign dbg_rr          = rr_q;
endmodule

// File: tb/tb_ysyx_23060187_rf_wb_arbiter.sv
// Bench for the write-back arbiter: directed vector table, hand-written
// reset/WAW sequences, then random traffic against a reference model.
module tb_ysyx_23060187_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk;
  logic rst;
  logic dbg_rr;

  ysyx_23060187_rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ysyx_23060187_rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .dbg_rr (dbg_rr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          rst;
    logic          iv;
    logic [AW-1:0] ird;
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [AW-1:0] qa1;
    logic [AW-1:0] qa2;
    logic          chk;
    logic          e_ir;
    logic          e_r0;
    logic          e_r1;
    logic          e_wen;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    logic          e_b1;
    logic          e_b2;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl[NV];

  function automatic vec_t mk(
    logic r, logic iv, logic [AW-1:0] ird,
    logic v0, logic [AW-1:0] a0, logic [DW-1:0] d0,
    logic v1, logic [AW-1:0] a1, logic [DW-1:0] d1,
    logic [AW-1:0] qa1, logic [AW-1:0] qa2, logic chk,
    logic e_ir, logic e_r0, logic e_r1,
    logic e_wen, logic [AW-1:0] e_wa, logic [DW-1:0] e_wd,
    logic e_b1, logic e_b2);
    vec_t v;
    v.rst = r; v.iv = iv; v.ird = ird;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.qa1 = qa1; v.qa2 = qa2; v.chk = chk;
    v.e_ir = e_ir; v.e_r0 = e_r0; v.e_r1 = e_r1;
    v.e_wen = e_wen; v.e_wa = e_wa; v.e_wd = e_wd;
    v.e_b1 = e_b1; v.e_b2 = e_b2;
    return v;
  endfunction

  // Driver tasks
  task automatic drive(input vec_t v);
    rst             = v.rst;
    bus.issue_valid = v.iv;
    bus.issue_rd    = v.ird;
    bus.req0_valid  = v.v0;
    bus.req0_addr   = v.a0;
    bus.req0_data   = v.d0;
    bus.req1_valid  = v.v1;
    bus.req1_addr   = v.a1;
    bus.req1_data   = v.d1;
    bus.q_addr1     = v.qa1;
    bus.q_addr2     = v.qa2;
  endtask

  task automatic idle_inputs();
    rst             = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.req0_valid  = 1'b0;
    bus.req0_addr   = '0;
    bus.req0_data   = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_addr   = '0;
    bus.req1_data   = '0;
    bus.q_addr1     = '0;
    bus.q_addr2     = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Scoreboard / reference model state for the random phase
  logic [AW+DW-1:0] exp_q[$];
  bit               m_busy[32];
  int               last_w;
  logic [AW-1:0]    m_wa;
  logic [DW-1:0]    m_wd;

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
    last_w = 1;
    m_wa   = '0;
    m_wd   = '0;
  endtask

  initial begin
    localparam logic [31:0] D = 32'hDEADBEEF;
    int n_wait;
    int got_c;
    bit h0, h1;

    idle_inputs();

    //           rst iv ird  v0 a0 d0        v1 a1 d1            qa1 qa2 chk ir r0 r1 wen wa wd        b1 b2
    tbl[0]  = mk(1, 0, 0,   1, 3, 32'h11,  1, 4, 32'h22,        0, 0, 0,  0, 0, 0, 0, 0, 32'h0,  0, 0);
    tbl[1]  = mk(1, 0, 0,   1, 3, 32'h11,  1, 4, 32'h22,        0, 0, 1,  1, 1, 0, 0, 0, 32'h0,  0, 0);
    tbl[2]  = mk(0, 0, 0,   0, 0, 32'h0,   0, 0, 32'h0,         5, 9, 1,  1, 0, 0, 0, 0, 32'h0,  0, 0);
    tbl[3]  = mk(0, 1, 5,   0, 0, 32'h0,   0, 0, 32'h0,         5, 9, 1,  1, 0, 0, 0, 0, 32'h0,  0, 0);
    tbl[4]  = mk(0, 0, 0,   1, 5, D,       0, 0, 32'h0,         5, 9, 1,  1, 1, 0, 0, 0, 32'h0,  1, 0);
    tbl[5]  = mk(0, 0, 0,   0, 0, 32'h0,   0, 0, 32'h0,         5, 9, 1,  1, 0, 0, 1, 5, D,      1, 0);
    tbl[6]  = mk(0, 0, 0,   0, 0, 32'h0,   0, 0, 32'h0,         5, 9, 1,  1, 0, 0, 0, 5, D,      0, 0);
    tbl[7]  = mk(0, 0, 0,   0, 0, 32'h0,   1, 0, 32'hFFFFFFFF,  5, 9, 1,  1, 0, 1, 0, 5, D,      0, 0);
    tbl[8]  = mk(0, 0, 0,   0, 0, 32'h0,   0, 0, 32'h0,         5, 9, 1,  1, 0, 0, 0, 5, D,      0, 0);
    tbl[9]  = mk(0, 0, 0,   1, 3, 32'h11,  1, 4, 32'h22,        3, 4, 1,  1, 1, 0, 0, 5, D,      0, 0);
    tbl[10] = mk(0, 0, 0,   1, 3, 32'h11,  1, 4, 32'h22,        3, 4, 1,  1, 0, 1, 1, 3, 32'h11, 0, 0);
    tbl[11] = mk(0, 0, 0,   1, 3, 32'h11,  1, 4, 32'h22,        3, 4, 1,  1, 1, 0, 1, 4, 32'h22, 0, 0);
    tbl[12] = mk(0, 0, 0,   1, 3, 32'h11,  1, 4, 32'h22,        3, 4, 1,  1, 0, 1, 1, 3, 32'h11, 0, 0);
    tbl[13] = mk(0, 0, 0,   0, 0, 32'h0,   0, 0, 32'h0,         3, 4, 1,  1, 0, 0, 1, 4, 32'h22, 0, 0);
    tbl[14] = mk(0, 1, 7,   0, 0, 32'h0,   0, 0, 32'h0,         7, 0, 1,  1, 0, 0, 0, 4, 32'h22, 0, 0);
    tbl[15] = mk(0, 1, 7,   1, 7, 32'h77,  0, 0, 32'h0,         7, 0, 1,  0, 1, 0, 0, 4, 32'h22, 1, 0);
    tbl[16] = mk(0, 1, 7,   0, 0, 32'h0,   0, 0, 32'h0,         7, 0, 1,  0, 0, 0, 1, 7, 32'h77, 1, 0);
    tbl[17] = mk(0, 1, 7,   0, 0, 32'h0,   0, 0, 32'h0,         7, 0, 1,  1, 0, 0, 0, 7, 32'h77, 0, 0);
    tbl[18] = mk(0, 0, 0,   0, 0, 32'h0,   0, 0, 32'h0,         7, 9, 1,  1, 0, 0, 0, 7, 32'h77, 1, 0);
    tbl[19] = mk(0, 0, 0,   0, 0, 32'h0,   1, 9, 32'h99,        7, 9, 1,  1, 0, 1, 0, 7, 32'h77, 1, 0);
    tbl[20] = mk(0, 1, 9,   0, 0, 32'h0,   0, 0, 32'h0,         7, 9, 1,  1, 0, 0, 1, 9, 32'h99, 1, 0);
    tbl[21] = mk(0, 0, 0,   0, 0, 32'h0,   0, 0, 32'h0,         7, 9, 1,  1, 0, 0, 0, 9, 32'h99, 1, 1);
    tbl[22] = mk(0, 0, 0,   1, 9, 32'h5A,  0, 0, 32'h0,         7, 9, 1,  1, 1, 0, 0, 9, 32'h99, 1, 1);
    tbl[23] = mk(0, 0, 0,   0, 0, 32'h0,   0, 0, 32'h0,         7, 9, 1,  1, 0, 0, 1, 9, 32'h5A, 1, 1);
    tbl[24] = mk(0, 0, 0,   0, 0, 32'h0,   0, 0, 32'h0,         7, 9, 1,  1, 0, 0, 0, 9, 32'h5A, 1, 0);
    tbl[25] = mk(0, 0, 0,   0, 0, 32'h0,   1, 7, 32'h70,        7, 9, 1,  1, 0, 1, 0, 9, 32'h5A, 1, 0);
    tbl[26] = mk(0, 0, 0,   0, 0, 32'h0,   0, 0, 32'h0,         7, 9, 1,  1, 0, 0, 1, 7, 32'h70, 1, 0);
    tbl[27] = mk(0, 0, 0,   0, 0, 32'h0,   0, 0, 32'h0,         7, 9, 1,  1, 0, 0, 0, 7, 32'h70, 0, 0);

    // Directed vector table: one row per cycle, outputs sampled mid-cycle
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      if (tbl[i].chk) begin
        check($sformatf("v%0d.issue_ready", i), 32'(bus.issue_ready), 32'(tbl[i].e_ir));
        check($sformatf("v%0d.req0_ready", i),  32'(bus.req0_ready),  32'(tbl[i].e_r0));
        check($sformatf("v%0d.req1_ready", i),  32'(bus.req1_ready),  32'(tbl[i].e_r1));
        check($sformatf("v%0d.rf_wen", i),      32'(bus.rf_wen),      32'(tbl[i].e_wen));
        check($sformatf("v%0d.rf_waddr", i),    32'(bus.rf_waddr),    32'(tbl[i].e_wa));
        check($sformatf("v%0d.rf_wdata", i),    bus.rf_wdata,         tbl[i].e_wd);
        check($sformatf("v%0d.q_busy1", i),     32'(bus.q_busy1),     32'(tbl[i].e_b1));
        check($sformatf("v%0d.q_busy2", i),     32'(bus.q_busy2),     32'(tbl[i].e_b2));
      end
    end

    // Reset while a write is staged: it must be dropped, scoreboard cleared
    @(negedge clk);
    idle_inputs();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd12;
    bus.q_addr1     = 5'd12;
    #1;
    check("rstdrop.issue_ready", 32'(bus.issue_ready), 32'd1);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.req0_valid  = 1'b1;
    bus.req0_addr   = 5'd12;
    bus.req0_data   = 32'hABCD;
    #1;
    check("rstdrop.req0_ready", 32'(bus.req0_ready), 32'd1);
    check("rstdrop.busy_set", 32'(bus.q_busy1), 32'd1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst            = 1'b1;
    #1;
    check("rstdrop.staged_wen", 32'(bus.rf_wen), 32'd1);
    check("rstdrop.staged_addr", 32'(bus.rf_waddr), 32'd12);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstdrop.wen_after", 32'(bus.rf_wen), 32'd0);
    check("rstdrop.waddr_after", 32'(bus.rf_waddr), 32'd0);
    check("rstdrop.wdata_after", bus.rf_wdata, 32'd0);
    check("rstdrop.busy_after", 32'(bus.q_busy1), 32'd0);
    check("rstdrop.rr_after", 32'(dbg_rr), 32'd0);

    // WAW: issue rd=20, LSU returns after a random delay; issue_ready must
    // reappear exactly two cycles after the LSU write is accepted.
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd20;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    n_wait = $urandom_range(1, 5);
    got_c  = 21;
    for (int c = 1; c <= 20; c++) begin
      bus.req1_valid = (c == n_wait);
      bus.req1_addr  = 5'd20;
      bus.req1_data  = 32'h2020;
      #1;
      if (bus.issue_ready) begin
        got_c = c;
        break;
      end
      @(negedge clk);
    end
    check("waw.ready_cycle", 32'(got_c), 32'(n_wait + 2));
    @(negedge clk);
    idle_inputs();

    // Random traffic against the reference model
    model_reset();
    h0 = 1'b0;
    h1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      int winner;
      bit has_w;
      bit e_ir;
      logic [AW+DW-1:0] ent;
      @(negedge clk);
      rst = (i == 0) || ($urandom_range(0, 49) == 0);
      if (!h0) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_addr  = AW'($urandom_range(0, 7));
        bus.req0_data  = $urandom;
      end
      if (!h1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_addr  = AW'($urandom_range(0, 7));
        bus.req1_data  = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 1) != 0);
      bus.issue_rd    = AW'($urandom_range(0, 7));
      bus.q_addr1     = AW'($urandom_range(0, 7));
      bus.q_addr2     = AW'($urandom_range(0, 7));
      #1;

      // Expected behaviour from the rules: lone requester wins, a tie goes
      // to whoever did not win last time.
      e_ir = !m_busy[bus.issue_rd];
      if (bus.req0_valid && bus.req1_valid) winner = 1 - last_w;
      else if (bus.req0_valid)              winner = 0;
      else if (bus.req1_valid)              winner = 1;
      else                                  winner = -1;
      has_w = (exp_q.size() > 0);
      if (has_w) begin
        ent  = exp_q.pop_front();
        m_wa = ent[AW+DW-1:DW];
        m_wd = ent[DW-1:0];
      end

      if (i > 0) begin
        check("rnd.issue_ready", 32'(bus.issue_ready), 32'(e_ir));
        check("rnd.req0_ready",  32'(bus.req0_ready),  32'(winner == 0));
        check("rnd.req1_ready",  32'(bus.req1_ready),  32'(winner == 1));
        check("rnd.rf_wen",      32'(bus.rf_wen),      32'(has_w));
        check("rnd.rf_waddr",    32'(bus.rf_waddr),    32'(m_wa));
        check("rnd.rf_wdata",    bus.rf_wdata,         m_wd);
        check("rnd.q_busy1",     32'(bus.q_busy1),     32'(m_busy[bus.q_addr1]));
        check("rnd.q_busy2",     32'(bus.q_busy2),     32'(m_busy[bus.q_addr2]));
        check("rnd.rr",          32'(dbg_rr),          32'(last_w == 0));
      end

      // Model update for the coming edge
      if (rst) begin
        model_reset();
      end else begin
        if (has_w) m_busy[m_wa] = 1'b0;
        if (bus.issue_valid && e_ir && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
        if (winner == 0) begin
          last_w = 0;
          if (bus.req0_addr != 0) exp_q.push_back({bus.req0_addr, bus.req0_data});
        end else if (winner == 1) begin
          last_w = 1;
          if (bus.req1_addr != 0) exp_q.push_back({bus.req1_addr, bus.req1_data});
        end
      end
      h0 = bus.req0_valid && (winner != 0);
      h1 = bus.req1_valid && (winner != 1);
    end

    // Final report
    @(negedge clk);
    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
